dmem_responder: RTL and testbench

- Data-memory responder for the pipelined core's load/store port. It sits on the memory side of the bus the core drives (address, write data, write strobe, DMType).
- Accepts one request at a time through a valid/ready handshake and inserts a programmable number of wait states.
- Performs byte, halfword or word stores using byte lanes.
- Returns sign- or zero-extended load data as a registered response pulse.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle rsp_valid pulse.
// Latency accept+WAIT_CYCLES+1; req_ready low while busy. Optional DMEM_MISALIGN_TRAP_EN adds err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_dmtype;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_sel_idle;
  logic        w_enter_resp;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic [2:0]  w_dm;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_sgn;
  logic        w_mis;
  logic        w_do_store;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_rsp_dat;
  logic        w_unused_addr;

  // With zero wait states the access resolves straight from the bus in IDLE.
  assign w_sel_idle   = (r_state == S_IDLE);
  assign w_enter_resp = (w_sel_idle && req_valid && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_addr  = w_sel_idle ? req_addr   : r_addr;
  assign w_wdata = w_sel_idle ? req_wdata  : r_wdata;
  assign w_we    = w_sel_idle ? req_we     : r_we;
  assign w_dm    = w_sel_idle ? req_dmtype : r_dmtype;

  assign w_is_half = (w_dm == 3'd1) || (w_dm == 3'd2);
  assign w_is_byte = (w_dm == 3'd3) || (w_dm == 3'd4);
  assign w_sgn     = (w_dm == 3'd1) || (w_dm == 3'd3);
  assign w_idx     = w_addr[AW+1:2];
  assign w_unused_addr = ^w_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = (w_is_half && w_addr[0]) ||
                 (!w_is_half && !w_is_byte && (w_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_be = 4'b1111;
    w_wd = w_wdata;
    if (w_is_byte) begin
      w_be = 4'b0001 << w_addr[1:0];
      w_wd = {4{w_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be = w_addr[1] ? 4'b1100 : 4'b0011;
      w_wd = {2{w_wdata[15:0]}};
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld = w_word;
    if (w_is_byte)      w_ld = {{24{w_sgn & w_byte[7]}}, w_byte};
    else if (w_is_half) w_ld = {{16{w_sgn & w_half[15]}}, w_half};
  end

  assign w_rsp_dat  = (w_we || w_mis) ? 32'd0 : w_ld;
  assign w_do_store = rst && w_enter_resp && w_we && !w_mis;

  // Array is deliberately outside reset; a reset edge blocks the commit.
  always_ff @(posedge clk) begin
    if (w_do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_we     <= 1'b0;
      r_dmtype <= 3'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_enter_resp) r_rdata <= w_rsp_dat;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_we     <= req_we;
            r_dmtype <= (req_dmtype > 3'd4) ? 3'd0 : req_dmtype;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_enter_resp && w_mis;
  end
  assign err = r_err;
`endif

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_WAIT) || (r_state == S_RESP);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random accesses against a byte-array model.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        v1, v3;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        rdy1, rdy3, vld1, vld3, busy1, busy3;
  logic [31:0] rd1, rd3;
  logic        sel;
  logic        rdy_s, vld_s, busy_s, err_s;
  logic [31:0] rdata_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl [4096];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dmtype(req_dmtype), .req_ready(rdy1),
    .rsp_valid(vld1), .rsp_rdata(rd1),
`ifdef DMEM_MISALIGN_TRAP_EN
    .err(err1),
`endif
    .busy(busy1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dmtype(req_dmtype), .req_ready(rdy3),
    .rsp_valid(vld3), .rsp_rdata(rd3),
`ifdef DMEM_MISALIGN_TRAP_EN
    .err(err3),
`endif
    .busy(busy3)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err1, err3;
  assign err_s = sel ? err3 : err1;
`else
  assign err_s = 1'b0;
`endif
  assign rdy_s   = sel ? rdy3  : rdy1;
  assign vld_s   = sel ? vld3  : vld1;
  assign busy_s  = sel ? busy3 : busy1;
  assign rdata_s = sel ? rd3   : rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: memory is 4096 bytes, little-endian, address taken modulo 4096.
  task automatic m_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] dt, output logic [31:0] rd, output logic er);
    int typ, size, off, base;
    bit sgn, mis;
    logic [31:0] v;
    typ  = (dt > 3'd4) ? 0 : int'(dt);
    size = (typ == 0) ? 4 : ((typ <= 2) ? 2 : 1);
    sgn  = (typ == 1) || (typ == 3);
    off  = int'(a % 4096);
    mis  = (off % size) != 0;
    rd = 32'd0;
    er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) begin
      er = 1'b1;
      return;
    end
`endif
    base = off - (off % size);
    if (we) begin
      for (int i = 0; i < size; i++) mdl[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mdl[base + i]) << (8 * i));
      if (size < 4 && sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endtask

  task automatic xact(input logic s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] dt, output logic [31:0] rd, output logic er);
    int k, lat, w;
    w = s ? 3 : 1;
    @(negedge clk);
    sel = s;
    req_we = we; req_addr = a; req_wdata = wd; req_dmtype = dt;
    if (s) v3 = 1'b1; else v1 = 1'b1;
    k = 0;
    while (!rdy_s && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_bound", (k < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1 v1 = 1'b0; v3 = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lat == 0 && vld_s) begin
        lat = c; rd = rdata_s; er = err_s;
      end
      if (lat != 0) c = 21;
    end
    check("latency", 32'(lat), 32'(w + 1));
    @(negedge clk);
    check("pulse_width", {31'd0, vld_s}, 32'd0);
    check("rdata_hold", rdata_s, rd);
  endtask

  task automatic run1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] dt, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer, er;
    xact(1'b0, we, a, wd, dt, rd, er);
    m_access(we, a, wd, dt, erd, eer);
    check("model_rdata", rd, erd);
    check("model_err", {31'd0, er}, {31'd0, eer});
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'd0;
    sel = 1'b0; rst = 1'b0; v1 = 1'b0; v3 = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_dmtype = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy1}, 32'd1);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_vld", {31'd0, vld1}, 32'd0);
    check("rst_rdata", rd1, 32'd0);
    check("rst_ready3", {31'd0, rdy3}, 32'd1);
    rst = 1'b1;

    for (int i = 0; i < 64; i++) run1(1'b1, 32'(i * 4), 32'd0, 3'd0, rd);

    run1(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, rd);
    check("sw_rdata_zero", rd, 32'd0);
    run1(1'b0, 32'h10, 32'd0, 3'd0, rd);
    check("lw_10", rd, 32'hDEADBEEF);

    run1(1'b1, 32'h20, 32'h11223344, 3'd0, rd);
    run1(1'b1, 32'h21, 32'h00000080, 3'd3, rd);
    run1(1'b0, 32'h21, 32'd0, 3'd4, rd);
    check("lbu_21", rd, 32'h00000080);
    run1(1'b0, 32'h21, 32'd0, 3'd3, rd);
    check("lb_21", rd, 32'hFFFFFF80);
    run1(1'b0, 32'h20, 32'd0, 3'd0, rd);
    check("lw_20_byte", rd, 32'h11228044);

    run1(1'b1, 32'h22, 32'h0000F00D, 3'd1, rd);
    run1(1'b0, 32'h20, 32'd0, 3'd0, rd);
    check("lw_20_half", rd, 32'hF00D8044);
    run1(1'b0, 32'h22, 32'd0, 3'd1, rd);
    check("lh_22", rd, 32'hFFFFF00D);
    run1(1'b0, 32'h22, 32'd0, 3'd2, rd);
    check("lhu_22", rd, 32'h0000F00D);
    run1(1'b0, 32'h20, 32'd0, 3'd7, rd);
    check("dmtype7_word", rd, 32'hF00D8044);
    run1(1'b0, 32'h1000_0020, 32'd0, 3'd0, rd);
    check("addr_wrap", rd, 32'hF00D8044);

    // Abort a store by pulling reset during its single wait state.
    @(negedge clk);
    sel = 1'b0;
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_dmtype = 3'd0; v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy1}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_vld", {31'd0, vld1}, 32'd0);
    check("abort_ready", {31'd0, rdy1}, 32'd1);
    check("abort_rdata", rd1, 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_vld", {31'd0, vld1}, 32'd0);
    end
    run1(1'b0, 32'h30, 32'd0, 3'd0, rd);
    check("lw_30_abort", rd, 32'd0);

    run1(1'b1, 32'h41, 32'hAABBCCDD, 3'd0, rd);
    run1(1'b0, 32'h40, 32'd0, 3'd0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_unchanged", rd, 32'd0);
    xact(1'b0, 1'b1, 32'h43, 32'h5555AAAA, 3'd1, rd, er);
    check("misalign_err", {31'd0, er}, 32'd1);
`else
    check("misalign_masked", rd, 32'hAABBCCDD);
`endif

    // Second request held on the bus while the first is in its wait states.
    @(negedge clk);
    sel = 1'b1;
    req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hCAFEF00D; req_dmtype = 3'd0; v3 = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("w3_ready_low", {31'd0, rdy3}, 32'd0);
      check("w3_busy_high", {31'd0, busy3}, 32'd1);
      check("w3_vld", {31'd0, vld3}, (c == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("w3_idle_ready", {31'd0, rdy3}, 32'd1);
    check("w3_idle_busy", {31'd0, busy3}, 32'd0);
    @(posedge clk);
    #1 v3 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("w3_second_vld", {31'd0, vld3}, (c == 4) ? 32'd1 : 32'd0);
    end
    check("w3_second_rdata", rd3, 32'hCAFEF00D);
    xact(1'b1, 1'b0, 32'h52, 32'd0, 3'd1, rd, er);
    check("w3_lh_52", rd, 32'hFFFFCAFE);

    for (int i = 0; i < 250; i++) begin
      ra = {$urandom_range(0, 32'hFFFFF), 4'h0, 8'($urandom_range(0, 255))};
      run1(1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
